// File: rtl/adxl355_spi_emu_pkg.sv
// Shared constants for the ADXL355 SPI emulator: register addresses, ID bytes,
// reset values of the writable configuration block and the SPI FSM state type.
package adxl355_pkg;

    localparam logic [6:0] ADDR_DEVID_AD  = 7'h00;
    localparam logic [6:0] ADDR_DEVID_MST = 7'h01;
    localparam logic [6:0] ADDR_PARTID    = 7'h02;
    localparam logic [6:0] ADDR_REVID     = 7'h03;
    localparam logic [6:0] ADDR_STATUS    = 7'h04;
    localparam logic [6:0] ADDR_XDATA3    = 7'h08;
    localparam logic [6:0] ADDR_XDATA2    = 7'h09;
    localparam logic [6:0] ADDR_XDATA1    = 7'h0A;
    localparam logic [6:0] ADDR_YDATA3    = 7'h0B;
    localparam logic [6:0] ADDR_YDATA2    = 7'h0C;
    localparam logic [6:0] ADDR_YDATA1    = 7'h0D;
    localparam logic [6:0] ADDR_ZDATA3    = 7'h0E;
    localparam logic [6:0] ADDR_ZDATA2    = 7'h0F;
    localparam logic [6:0] ADDR_ZDATA1    = 7'h10;
    localparam logic [6:0] ADDR_WR_FIRST  = 7'h1E;
    localparam logic [6:0] ADDR_RANGE     = 7'h2C;
    localparam logic [6:0] ADDR_POWER_CTL = 7'h2D;
    localparam logic [6:0] ADDR_RESET     = 7'h2F;
    localparam logic [6:0] ADDR_WR_LAST   = 7'h2F;

    localparam int WR_REG_COUNT = 18;

    localparam logic [7:0] DEVID_AD_VAL   = 8'hAD;
    localparam logic [7:0] DEVID_MST_VAL  = 8'h1D;
    localparam logic [7:0] PARTID_VAL     = 8'hED;
    localparam logic [7:0] REVID_VAL      = 8'h01;
    localparam logic [7:0] RESET_CODE     = 8'h52;
    localparam logic [7:0] RANGE_RST      = 8'h81;
    localparam logic [7:0] POWER_CTL_RST  = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } spi_state_e;

    function automatic logic [7:0] wr_reset_value(input logic [6:0] addr);
        case (addr)
            ADDR_RANGE:     return RANGE_RST;
            ADDR_POWER_CTL: return POWER_CTL_RST;
            default:        return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/adxl355_spi_emu_if.sv
// SPI pin bundle between the ESP32 initiator (master) and the emulator (slave).
interface adxl355_spi_emu_if;
    logic csn;
    logic sclk;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output csn, output sclk, output mosi, input miso, input miso_oe);
    modport slave  (input csn, input sclk, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/adxl355_spi_emu_spi_slave_byte.sv
// SPI mode-0 byte engine: pin synchronizers, edge detection, bit counter and
// MSB-first shift registers; the register/FSM logic lives in the top.
module spi_slave_byte #(
    parameter int SCLK_SYNC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       csn_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic [7:0] tx_byte_i,
    output logic [7:0] byte_rx_o,
    output logic       byte_done_o,
    output logic       load_o,
    output logic       cs_start_o,
    output logic       cs_end_o,
    output logic       cs_active_o,
    output logic       miso_o,
    output logic       miso_oe_o
);

    logic [SCLK_SYNC-1:0] csn_sync_q;
    logic [SCLK_SYNC-1:0] sclk_sync_q;
    logic [SCLK_SYNC-1:0] mosi_sync_q;
    logic                 csn_prev_q;
    logic                 sclk_prev_q;
    logic [2:0]           bit_cnt_q;
    logic [7:0]           rx_q;
    logic [7:0]           tx_q;
    logic                 any_byte_q;
    logic                 byte_done_q;
    logic                 miso_q;
    logic                 miso_oe_q;

    logic csn_s;
    logic sclk_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;

    assign csn_s  = csn_sync_q[SCLK_SYNC-1];
    assign sclk_s = sclk_sync_q[SCLK_SYNC-1];
    assign mosi_s = mosi_sync_q[SCLK_SYNC-1];

    assign cs_active_o = !csn_s;
    assign cs_start_o  = csn_prev_q && !csn_s;
    assign cs_end_o    = !csn_prev_q && csn_s;
    assign sclk_rise   = cs_active_o && sclk_s && !sclk_prev_q;
    assign sclk_fall   = cs_active_o && !sclk_s && sclk_prev_q;

    // A new transmit byte is due on the first fall after a completed byte.
    assign load_o      = sclk_fall && (bit_cnt_q == 3'd0) && any_byte_q;

    assign byte_rx_o   = rx_q;
    assign byte_done_o = byte_done_q;
    assign miso_o      = miso_q;
    assign miso_oe_o   = miso_oe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn_sync_q  <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            csn_sync_q  <= (csn_sync_q << 1) | SCLK_SYNC'(csn_i);
            sclk_sync_q <= (sclk_sync_q << 1) | SCLK_SYNC'(sclk_i);
            mosi_sync_q <= (mosi_sync_q << 1) | SCLK_SYNC'(mosi_i);
            csn_prev_q  <= csn_s;
            sclk_prev_q <= sclk_s;
        end
    end

    // Everything is cleared while deselected, so a partial byte never completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            any_byte_q  <= 1'b0;
            byte_done_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            miso_oe_q <= cs_active_o;
            miso_q    <= cs_active_o && tx_q[7];
            if (!cs_active_o || cs_start_o) begin
                bit_cnt_q   <= 3'd0;
                rx_q        <= 8'h00;
                tx_q        <= 8'h00;
                any_byte_q  <= 1'b0;
                byte_done_q <= 1'b0;
            end else begin
                byte_done_q <= 1'b0;
                if (sclk_rise) begin
                    rx_q      <= {rx_q[6:0], mosi_s};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done_q <= 1'b1;
                        any_byte_q  <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (load_o) begin
                        tx_q <= tx_byte_i;
                    end else begin
                        tx_q <= {tx_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/adxl355_spi_emu.sv
// ADXL355 register-interface emulator on the SPI slave side. Define
// ADXL355_EMU_WRITE_EN to back 0x1E-0x2F with a writable, read-back image.
module adxl355_spi_emu
    import adxl355_pkg::*;
#(
    parameter int SCLK_SYNC = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    adxl355_spi_emu_if.slave       spi,
    input  logic [19:0]            sample_x,
    input  logic [19:0]            sample_y,
    input  logic [19:0]            sample_z,
    input  logic                   sample_valid,
    output logic                   drdy,
    output logic                   wr_stb,
    output logic [6:0]             wr_addr,
    output logic [7:0]             wr_data
);

    spi_state_e  state_q;
    logic [6:0]  addr_q;
    logic        rw_q;
    logic        wr_stb_q;
    logic [6:0]  wr_addr_q;
    logic [7:0]  wr_data_q;

    logic [19:0] x_q, y_q, z_q;
    logic [19:0] pend_x_q, pend_y_q, pend_z_q;
    logic        pend_valid_q;
    logic        drdy_q;

    logic [7:0]  byte_rx;
    logic        byte_done;
    logic        load;
    logic        cs_start;
    logic        cs_end;
    logic        cs_active;
    logic [7:0]  read_data_d;
    logic [7:0]  tx_byte_d;
    logic        wr_fire;
    logic        rdy_clear;

    spi_slave_byte #(
        .SCLK_SYNC (SCLK_SYNC)
    ) u_byte (
        .clk         (clk),
        .rst_n       (resetn),
        .csn_i       (spi.csn),
        .sclk_i      (spi.sclk),
        .mosi_i      (spi.mosi),
        .tx_byte_i   (tx_byte_d),
        .byte_rx_o   (byte_rx),
        .byte_done_o (byte_done),
        .load_o      (load),
        .cs_start_o  (cs_start),
        .cs_end_o    (cs_end),
        .cs_active_o (cs_active),
        .miso_o      (spi.miso),
        .miso_oe_o   (spi.miso_oe)
    );

    assign wr_fire   = (state_q == ST_DATA) && byte_done && !rw_q;
    assign rdy_clear = load && (state_q == ST_DATA) && rw_q && (addr_q == ADDR_XDATA3);
    assign tx_byte_d = ((state_q == ST_DATA) && rw_q) ? read_data_d : 8'h00;

`ifdef ADXL355_EMU_WRITE_EN
    logic [7:0] wr_regs_q [WR_REG_COUNT];
    logic [4:0] wr_idx;
    logic       wr_hit;

    assign wr_idx = 5'(addr_q - ADDR_WR_FIRST);
    assign wr_hit = (addr_q >= ADDR_WR_FIRST) && (addr_q <= ADDR_WR_LAST);

    // Writing the reset code to the RESET register reloads the whole block.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < WR_REG_COUNT; i++) begin
                wr_regs_q[i] <= wr_reset_value(ADDR_WR_FIRST + 7'(i));
            end
        end else if (wr_fire && wr_hit) begin
            if (addr_q == ADDR_RESET && byte_rx == RESET_CODE) begin
                for (int i = 0; i < WR_REG_COUNT; i++) begin
                    wr_regs_q[i] <= wr_reset_value(ADDR_WR_FIRST + 7'(i));
                end
            end else begin
                wr_regs_q[wr_idx] <= byte_rx;
            end
        end
    end
`endif

    always_comb begin
        read_data_d = 8'h00;
        case (addr_q)
            ADDR_DEVID_AD:  read_data_d = DEVID_AD_VAL;
            ADDR_DEVID_MST: read_data_d = DEVID_MST_VAL;
            ADDR_PARTID:    read_data_d = PARTID_VAL;
            ADDR_REVID:     read_data_d = REVID_VAL;
            ADDR_STATUS:    read_data_d = {7'b0, drdy_q};
            ADDR_XDATA3:    read_data_d = x_q[19:12];
            ADDR_XDATA2:    read_data_d = x_q[11:4];
            ADDR_XDATA1:    read_data_d = {x_q[3:0], 4'h0};
            ADDR_YDATA3:    read_data_d = y_q[19:12];
            ADDR_YDATA2:    read_data_d = y_q[11:4];
            ADDR_YDATA1:    read_data_d = {y_q[3:0], 4'h0};
            ADDR_ZDATA3:    read_data_d = z_q[19:12];
            ADDR_ZDATA2:    read_data_d = z_q[11:4];
            ADDR_ZDATA1:    read_data_d = {z_q[3:0], 4'h0};
            default:        read_data_d = 8'h00;
        endcase
`ifdef ADXL355_EMU_WRITE_EN
        if (wr_hit) begin
            read_data_d = wr_regs_q[wr_idx];
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= 7'h00;
            rw_q      <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 7'h00;
            wr_data_q <= 8'h00;
        end else begin
            wr_stb_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs_start) begin
                        state_q <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        addr_q  <= byte_rx[7:1];
                        rw_q    <= byte_rx[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_done) begin
                        if (!rw_q) begin
                            wr_stb_q  <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= byte_rx;
                        end
                        addr_q <= addr_q + 7'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (!cs_active) begin
                state_q <= ST_IDLE;
            end
        end
    end

    // Samples arriving mid-transaction are parked so a burst reads one coherent
    // sample; a direct capture is the newest data and so is applied last.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q          <= 20'h0;
            y_q          <= 20'h0;
            z_q          <= 20'h0;
            pend_x_q     <= 20'h0;
            pend_y_q     <= 20'h0;
            pend_z_q     <= 20'h0;
            pend_valid_q <= 1'b0;
            drdy_q       <= 1'b0;
        end else begin
            if (rdy_clear) begin
                drdy_q <= 1'b0;
            end
            if (cs_end && pend_valid_q) begin
                x_q          <= pend_x_q;
                y_q          <= pend_y_q;
                z_q          <= pend_z_q;
                pend_valid_q <= 1'b0;
                drdy_q       <= 1'b1;
            end
            if (sample_valid) begin
                if (cs_active) begin
                    pend_x_q     <= sample_x;
                    pend_y_q     <= sample_y;
                    pend_z_q     <= sample_z;
                    pend_valid_q <= 1'b1;
                end else begin
                    x_q    <= sample_x;
                    y_q    <= sample_y;
                    z_q    <= sample_z;
                    drdy_q <= 1'b1;
                end
            end
        end
    end

    assign drdy    = drdy_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_adxl355_spi_emu.sv
// Directed bench for adxl355_spi_emu: drives SPI mode-0 transactions at clk/16
// and compares MISO bytes, DRDY and the write strobe against hand-computed values.
module tb_adxl355_spi_emu;

`ifdef ADXL355_EMU_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif
    localparam int HALF = 8;

    logic        clk;
    logic        resetn;
    logic [19:0] sample_x, sample_y, sample_z;
    logic        sample_valid;
    logic        drdy;
    logic        wr_stb;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;

    int          vectors;
    int          errors;
    int          stbCount;
    int          expStb;
    logic [6:0]  lastAddr;
    logic [7:0]  lastData;
    logic [7:0]  rx;
    logic [7:0]  expQ[$];
    logic [7:0]  wrQ[$];

    adxl355_spi_emu_if spi ();

    adxl355_spi_emu #(
        .SCLK_SYNC (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .spi          (spi.slave),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .sample_valid (sample_valid),
        .drdy         (drdy),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb) begin
            stbCount++;
            lastAddr = wr_addr;
            lastData = wr_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spiBegin();
        spi.csn = 1'b0;
        waitClocks(HALF);
    endtask

    task automatic spiEnd();
        waitClocks(HALF);
        spi.csn  = 1'b1;
        spi.mosi = 1'b0;
        waitClocks(HALF);
    endtask

    // Shifts nbits MSB-first; MISO is sampled at each rising SCLK.
    task automatic applyStimulus(input logic [7:0] tx, input int nbits, output logic [7:0] rxByte);
        rxByte = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi.mosi = tx[i];
            waitClocks(HALF);
            spi.sclk = 1'b1;
            rxByte[i] = spi.miso;
            waitClocks(HALF);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic readBurst(input string tag, input logic [7:0] cmd);
        logic [7:0] r;
        spiBegin();
        applyStimulus(cmd, 8, r);
        for (int i = 0; i < expQ.size(); i++) begin
            applyStimulus(8'h00, 8, r);
            checkOutput($sformatf("%s[%0d]", tag, i), {24'h0, r}, {24'h0, expQ[i]});
        end
        spiEnd();
    endtask

    task automatic writeBurst(input logic [7:0] cmd);
        logic [7:0] r;
        spiBegin();
        applyStimulus(cmd, 8, r);
        for (int i = 0; i < wrQ.size(); i++) begin
            applyStimulus(wrQ[i], 8, r);
        end
        spiEnd();
    endtask

    task automatic pulseSample(input logic [19:0] x, input logic [19:0] y, input logic [19:0] z);
        sample_x     = x;
        sample_y     = y;
        sample_z     = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vectors      = 0;
        errors       = 0;
        stbCount     = 0;
        expStb       = 0;
        lastAddr     = 7'h0;
        lastData     = 8'h0;
        resetn       = 1'b0;
        spi.csn      = 1'b1;
        spi.sclk     = 1'b0;
        spi.mosi     = 1'b0;
        sample_x     = 20'h0;
        sample_y     = 20'h0;
        sample_z     = 20'h0;
        sample_valid = 1'b0;
        waitClocks(4);
        checkOutput("rst_miso", {31'h0, spi.miso}, 32'h0);
        checkOutput("rst_miso_oe", {31'h0, spi.miso_oe}, 32'h0);
        checkOutput("rst_drdy", {31'h0, drdy}, 32'h0);
        checkOutput("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
        resetn = 1'b1;
        waitClocks(4);

        // ID burst, also checks output-enable while selected
        spiBegin();
        checkOutput("miso_oe_sel", {31'h0, spi.miso_oe}, 32'h1);
        applyStimulus(8'h01, 8, rx);
        checkOutput("miso_cmd", {24'h0, rx}, 32'h0);
        expQ = {8'hAD, 8'h1D, 8'hED, 8'h01};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, 8, rx);
            checkOutput($sformatf("id[%0d]", i), {24'h0, rx}, {24'h0, expQ[i]});
        end
        spiEnd();
        checkOutput("miso_oe_desel", {31'h0, spi.miso_oe}, 32'h0);

        // Capture while idle, STATUS then full XYZ burst
        pulseSample(20'h12345, 20'hABCDE, 20'h00001);
        checkOutput("drdy_set", {31'h0, drdy}, 32'h1);
        expQ = {8'h01};
        readBurst("status1", 8'h09);
        expQ = {8'h12, 8'h34, 8'h50, 8'hAB, 8'hCD, 8'hE0, 8'h00, 8'h00, 8'h10};
        readBurst("xyz", 8'h11);
        checkOutput("drdy_clr", {31'h0, drdy}, 32'h0);
        expQ = {8'h00};
        readBurst("status0", 8'h09);

        // Mid-burst sample is parked until deselect
        spiBegin();
        applyStimulus(8'h11, 8, rx);
        applyStimulus(8'h00, 8, rx);
        checkOutput("coh[0]", {24'h0, rx}, 32'h12);
        pulseSample(20'hFFFFF, 20'hABCDE, 20'h00001);
        checkOutput("drdy_pend", {31'h0, drdy}, 32'h0);
        applyStimulus(8'h00, 8, rx);
        checkOutput("coh[1]", {24'h0, rx}, 32'h34);
        applyStimulus(8'h00, 8, rx);
        checkOutput("coh[2]", {24'h0, rx}, 32'h50);
        spiEnd();
        checkOutput("drdy_pend_apply", {31'h0, drdy}, 32'h1);
        expQ = {8'hFF, 8'hFF, 8'hF0};
        readBurst("newx", 8'h11);

        // Writes to POWER_CTL, then soft reset through RESET
        expQ = {WR_EN ? 8'h01 : 8'h00};
        readBurst("pwr_rst", 8'h5B);
        wrQ = {8'h00};
        writeBurst(8'h5A);
        expStb++;
        checkOutput("wr_stb_cnt1", stbCount, expStb);
        checkOutput("wr_addr1", {25'h0, lastAddr}, 32'h2D);
        checkOutput("wr_data1", {24'h0, lastData}, 32'h00);
        expQ = {8'h00};
        readBurst("pwr_wr", 8'h5B);
        wrQ = {8'h52};
        writeBurst(8'h5E);
        expStb++;
        checkOutput("wr_addr2", {25'h0, lastAddr}, 32'h2F);
        checkOutput("wr_data2", {24'h0, lastData}, 32'h52);
        expQ = {WR_EN ? 8'h01 : 8'h00};
        readBurst("pwr_soft", 8'h5B);
        expQ = {WR_EN ? 8'h81 : 8'h00};
        readBurst("range_soft", 8'h59);

        // Write burst auto-increments the address
        wrQ = {8'h11, 8'h22};
        writeBurst(8'h3C);
        expStb += 2;
        checkOutput("wr_stb_cnt3", stbCount, expStb);
        checkOutput("wr_addr3", {25'h0, lastAddr}, 32'h1F);
        checkOutput("wr_data3", {24'h0, lastData}, 32'h22);
        expQ = {WR_EN ? 8'h11 : 8'h00, WR_EN ? 8'h22 : 8'h00};
        readBurst("wrburst", 8'h3D);

        // Address wrap 0x7F -> 0x00
        expQ = {8'h00, 8'hAD};
        readBurst("wrap", 8'hFF);

        // Partial write byte is discarded
        spiBegin();
        applyStimulus(8'h5A, 8, rx);
        applyStimulus(8'hFF, 5, rx);
        spiEnd();
        checkOutput("partial_stb", stbCount, expStb);
        expQ = {WR_EN ? 8'h01 : 8'h00};
        readBurst("partial_pwr", 8'h5B);
        expQ = {8'hAD};
        readBurst("after_partial", 8'h01);

        // Reset in the middle of a burst
        pulseSample(20'h54321, 20'h0, 20'h0);
        checkOutput("drdy_pre_rst", {31'h0, drdy}, 32'h1);
        spiBegin();
        applyStimulus(8'h11, 4, rx);
        resetn = 1'b0;
        waitClocks(2);
        checkOutput("mrst_miso", {31'h0, spi.miso}, 32'h0);
        checkOutput("mrst_miso_oe", {31'h0, spi.miso_oe}, 32'h0);
        checkOutput("mrst_drdy", {31'h0, drdy}, 32'h0);
        checkOutput("mrst_wr_stb", {31'h0, wr_stb}, 32'h0);
        checkOutput("mrst_wr_addr", {25'h0, wr_addr}, 32'h0);
        checkOutput("mrst_wr_data", {24'h0, wr_data}, 32'h0);
        spi.csn  = 1'b1;
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        waitClocks(4);
        resetn = 1'b1;
        waitClocks(4);
        expQ = {8'h00, 8'h00, 8'h00};
        readBurst("post_rst_x", 8'h11);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/adxl355_spi_emu.md
# adxl355_spi_emu

SPI-slave emulator of the ADXL355 accelerometer register interface, sitting on the same PMOD/ESP32 SPI wires a real sensor would occupy. The ESP32 stays the initiator and this block is the responder. It answers ADXL355-format register reads from an internal register image, with X/Y/Z data fed by on-chip logic, and it accepts register writes. Firmware can therefore run unchanged against synthetic or FPGA-processed acceleration data.

## Interface
- `SCLK_SYNC`, default 2: synchronizer depth for `csn`/`sclk`/`mosi`.
- `clk`  in  1: system clock (25 MHz); SCLK must be ≤ clk/8.
- `resetn`  in  1: asynchronous, active-low reset.
- `csn`  in  1: SPI chip select, active low.
- `sclk`  in  1: SPI clock, mode 0 (CPOL=0, CPHA=0).
- `mosi`  in  1: SPI data in.
- `miso`  out  1: SPI data out.
- `miso_oe`  out  1: high while `csn` (synchronized) is low.
- `sample_x`, `sample_y`, `sample_z`  in  20 each: two's-complement acceleration.
- `sample_valid`  in  1: one-clk strobe that presents a new sample.
- `drdy`  out  1: mirrors STATUS.DATA_RDY.
- `wr_stb`  out  1: one-clk pulse per completed SPI write byte.
- `wr_addr`  out  7: address of that write.
- `wr_data`  out  8: data of that write.

## Operation
- Inputs pass through a `SCLK_SYNC`-flop synchronizer, then edge detection produces rise/fall strobes for `sclk` and a fall/rise strobe for `csn`.
- FSM states:
  - IDLE: `csn` high. `csn` fall → CMD, bit counter 0.
  - CMD: shift 8 `mosi` bits on `sclk` rises. Byte = {addr[6:0], rw}, rw=1 means read. On the 8th rise, latch addr and go to DATA.
  - DATA: each byte is 8 bits.
    - Read: load shift register from reg[addr] on the `sclk` fall after the last CMD/DATA rise. Shift MSB-first on each fall.
    - Write: on each 8th rise, pulse `wr_stb` with addr/data and update the writable reg.
    - After every byte, addr increments and wraps 0x7F→0x00.
  - Any state: `csn` rise → IDLE, immediately and mid-byte. A partial byte is discarded and produces no `wr_stb`.
- MISO outputs 0 during CMD.
- Register map:
  - Read-only identification: 0x00=0xAD, 0x01=0x1D, 0x02=0xED, 0x03=0x01.
  - 0x04 STATUS: bit0 DATA_RDY, other bits 0. 0x05–0x07 read 0.
  - X data: 0x08=x[19:12], 0x09=x[11:4], 0x0A={x[3:0],4'h0}. Y data at 0x0B–0x0D, Z data at 0x0E–0x10, same layout.
  - Unmapped addresses read 0x00.
- Sample handling:
  - `sample_valid` with `csn` high: copy to the data image and set DATA_RDY.
  - `sample_valid` with `csn` low: store in a pending buffer, applied on `csn` rise. This keeps reads coherent within one transaction.
  - A newer pending sample overwrites an older pending one.
- DATA_RDY clears when address 0x08 is loaded for a read. If a capture and that clear happen in the same clk, set wins.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `drdy`=0, `wr_stb`=0, `wr_addr`=0, `wr_data`=0. FSM in IDLE, data image 0, pending buffer empty.
- Latency from pin to `miso` change is `SCLK_SYNC`+2 clk after the `sclk` fall. This stays within a half SCLK period at clk/8.
- `wr_stb` asserts `SCLK_SYNC`+2 clk after the 8th rise of the byte.
- `drdy` updates 1 clk after capture.

## Configuration
- `ADXL355_EMU_WRITE_EN` defined: writable image for 0x1E–0x2F. Reset values: 0x2C RANGE=0x81, 0x2D POWER_CTL=0x01, all others 0x00. These registers read back. Writing 0x52 to 0x2F restores the reset values.
- Undefined: those addresses read 0x00 and writes are dropped. `wr_stb`/`wr_addr`/`wr_data` still report every write.

## Structure
- Package `adxl355_pkg` holds:
  - Register address localparams: ID, STATUS, XDATA3…ZDATA1, RANGE, POWER_CTL, RESET.
  - ID constants, reset-code 0x52, and reset values.
  - FSM state enum.
- One sub-module, `spi_slave_byte`: synchronizer, edge detect, bit counter, shift in/out. It exposes `byte_rx`/`byte_done`/`load`/`cs_start`/`cs_end` to the top's register and FSM logic.

## Test plan
- Read 0x00, burst 4 (cmd 0x01) → MISO bytes 0xAD,0x1D,0xED,0x01.
- `sample_x`=20'h12345 with valid, `csn` high, then burst read from 0x08, 3 bytes → 0x12,0x34,0x50. `drdy` goes 1 and then 0 after the read.
- `sample_valid` with x=20'hFFFFF mid-burst at 0x09 → the rest of the burst returns old data. The new value is readable after `csn` rise.
- Write cmd 0x5A (addr 0x2D, W), data 0x00 → `wr_stb`, `wr_addr`=0x2D, `wr_data`=0x00. A readback gives 0x00 with WRITE_EN defined and 0x00 without. Then write 0x52 to 0x2F → 0x2D reads 0x01 with the macro defined.
- Read cmd 0xFF (addr 0x7F), 2 bytes → 0x00, then 0xAD (wraps to 0x00).
- `csn` raised after 5 bits of a write byte → no `wr_stb`. The next transaction decodes correctly. `resetn` low mid-burst → all outputs return to their reset values.
